rvfi_htif_ctrl: RTL and testbench

Host-target interface (HTIF) sequencer for the CVA6 testbench. Watches the RVFI commit ports for stores to `tohost` and decides whether each is a test exit or a syscall. For a syscall it runs a request/acknowledge exchange with the host model, then writes the host response back to `fromhost`. It also owns the simulation timeout and drives the testbench `end_of_test` code.

---
 rtl/rvfi_htif_pkg.sv | 43 ++++
 rtl/rvfi_htif_match.sv | 55 +++++
 rtl/rvfi_htif_ctrl.sv | 172 +++++++++++++++++
 tb/tb_rvfi_htif_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvfi_htif_pkg.sv
// Shared types and constants for the HTIF sequencer.
// Optional syscall path is controlled by the RVFI_HTIF_SYSCALL_EN macro (see rvfi_htif_ctrl).
package rvfi_htif_pkg;

    // Sequencer states; REQ and FH_WR are only reachable when syscalls are built in.
    typedef enum logic [1:0] {
        HTIF_IDLE  = 2'd0,
        HTIF_REQ   = 2'd1,
        HTIF_FH_WR = 2'd2,
        HTIF_DONE  = 2'd3
    } htif_state_e;

    localparam logic [31:0] HTIF_TIMEOUT_CODE = 32'hFFFF_FFFF;
    localparam logic [7:0]  HTIF_DROP_MAX     = 8'd255;

    // Minimal core configuration: only the commit port count matters here.
    typedef struct packed {
        int unsigned NrCommitPorts;
    } htif_cfg_t;

    localparam htif_cfg_t htif_cfg_default = '{NrCommitPorts: 32'd2};

    // Default RVFI commit record carrying just the fields the sequencer inspects.
    typedef struct packed {
        logic        valid;
        logic [7:0]  mem_wmask;
        logic [63:0] mem_paddr;
        logic [63:0] mem_wdata;
    } htif_rvfi_instr_t;

    // Port index width, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // 8-bit add that clamps at HTIF_DROP_MAX instead of wrapping.
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? HTIF_DROP_MAX : sum[7:0];
    endfunction

endpackage

// File: rtl/rvfi_htif_match.sv
// Per-port tohost store detection with lowest-index priority selection.
// Purely combinational; the parent registers everything it derives from these outputs.
module rvfi_htif_match
    import rvfi_htif_pkg::*;
#(
    parameter int unsigned NR_PORTS     = 2,
    parameter type         rvfi_instr_t = htif_rvfi_instr_t,
    parameter int unsigned IDX_W        = idx_width(NR_PORTS)
) (
    input  rvfi_instr_t       rvfi_i [NR_PORTS],
    input  logic [63:0]       tohost_addr_i,
    output logic              hit,
    output logic [IDX_W-1:0]  idx,
    output logic [63:0]       wdata,
    output logic [7:0]        extra_hits
);

    logic [NR_PORTS-1:0] match_vec;
    logic [7:0]          match_cnt;

    // A port matches only for a real, non-zero store to a configured tohost address.
    generate
        for (genvar gi = 0; gi < NR_PORTS; gi++) begin : g_port
            assign match_vec[gi] = rvfi_i[gi].valid
                                && (rvfi_i[gi].mem_wmask != '0)
                                && (rvfi_i[gi].mem_paddr == tohost_addr_i)
                                && (rvfi_i[gi].mem_wdata != '0)
                                && (tohost_addr_i != '0);
        end
    endgenerate

    // Scan from the top so the lowest matching index ends up selected.
    always_comb begin
        hit   = 1'b0;
        idx   = '0;
        wdata = '0;
        for (int i = int'(NR_PORTS) - 1; i >= 0; i--) begin
            if (match_vec[i]) begin
                hit   = 1'b1;
                idx   = IDX_W'(i);
                wdata = rvfi_i[i].mem_wdata;
            end
        end
    end

    // Every match other than the selected one is reported as an extra hit.
    always_comb begin
        match_cnt = '0;
        for (int i = 0; i < int'(NR_PORTS); i++) begin
            match_cnt = match_cnt + {7'd0, match_vec[i]};
        end
        extra_hits = match_cnt - {7'd0, hit};
    end

endmodule

// File: rtl/rvfi_htif_ctrl.sv
// HTIF sequencer: exit detection, syscall request/ack, fromhost write-back, timeout.
// Macro RVFI_HTIF_SYSCALL_EN builds the REQ/FH_WR syscall path; without it,
// syscall stores are only counted as dropped and the syscall outputs are tied low.
module rvfi_htif_ctrl
    import rvfi_htif_pkg::*;
#(
    parameter htif_cfg_t   CVA6Cfg        = htif_cfg_default,
    parameter type         rvfi_instr_t   = htif_rvfi_instr_t,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd2000000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  rvfi_instr_t rvfi_i [CVA6Cfg.NrCommitPorts],
    input  logic [63:0] tohost_addr_i,
    input  logic [63:0] fromhost_addr_i,
    output logic        sys_req_o,
    output logic [63:0] sys_payload_o,
    input  logic        sys_ack_i,
    input  logic [63:0] sys_resp_i,
    output logic        fh_we_o,
    output logic [63:0] fh_addr_o,
    output logic [63:0] fh_wdata_o,
    input  logic        fh_gnt_i,
    output logic        busy_o,
    output logic [7:0]  dropped_o,
    output logic [31:0] end_of_test_o
);

    localparam int unsigned NR_PORTS = CVA6Cfg.NrCommitPorts;
    localparam int unsigned IDX_W    = idx_width(NR_PORTS);

    htif_state_e      state_reg, state_next;
    logic [31:0]      eot_reg, eot_next;
    logic [7:0]       drop_reg, drop_next, drop_inc;
    logic [31:0]      cnt_reg, cnt_next;
    logic [63:0]      fh_addr_reg;
    logic             exit_take;
    logic             timeout_hit;

    logic             m_hit;
    logic [IDX_W-1:0] m_idx;
    logic [63:0]      m_wdata;
    logic [7:0]       m_extra;

    rvfi_htif_match #(
        .NR_PORTS     (NR_PORTS),
        .rvfi_instr_t (rvfi_instr_t),
        .IDX_W        (IDX_W)
    ) u_match (
        .rvfi_i        (rvfi_i),
        .tohost_addr_i (tohost_addr_i),
        .hit           (m_hit),
        .idx           (m_idx),
        .wdata         (m_wdata),
        .extra_hits    (m_extra)
    );

    // The counter is compared as a register so the timeout fires one cycle after it reaches the limit.
    assign timeout_hit = (TIMEOUT_CYCLES != 32'd0) && (cnt_reg >= TIMEOUT_CYCLES);
    assign cnt_next    = (cnt_reg == 32'hFFFF_FFFF) ? cnt_reg : cnt_reg + 32'd1;
    assign drop_next   = sat_add8(drop_reg, drop_inc);

    // Next-state, exit latching and drop accounting; timeout overrides all but a same-cycle exit.
    always_comb begin
        state_next = state_reg;
        eot_next   = eot_reg;
        exit_take  = 1'b0;
        // Outside IDLE every match, including the would-be selected one, is dropped.
        drop_inc   = m_extra + ((state_reg != HTIF_IDLE) ? {7'd0, m_hit} : 8'd0);
        case (state_reg)
            HTIF_IDLE: begin
                if (m_hit) begin
                    if (m_wdata[0]) begin
                        exit_take  = 1'b1;
                        eot_next   = m_wdata[31:0];
                        state_next = HTIF_DONE;
                    end else begin
`ifdef RVFI_HTIF_SYSCALL_EN
                        state_next = HTIF_REQ;
`else
                        drop_inc   = m_extra + 8'd1;
`endif
                    end
                end
            end
`ifdef RVFI_HTIF_SYSCALL_EN
            HTIF_REQ: begin
                if (sys_ack_i) begin
                    state_next = (fromhost_addr_i != '0) ? HTIF_FH_WR : HTIF_IDLE;
                end
            end
            HTIF_FH_WR: begin
                if (fh_gnt_i) begin
                    state_next = HTIF_IDLE;
                end
            end
`endif
            default: ;
        endcase
        if (timeout_hit && (state_reg != HTIF_DONE) && !exit_take) begin
            state_next = HTIF_DONE;
            eot_next   = HTIF_TIMEOUT_CODE;
        end
    end

    // State, exit code, drop counter, cycle counter and fromhost address registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg   <= HTIF_IDLE;
            eot_reg     <= '0;
            drop_reg    <= '0;
            cnt_reg     <= '0;
            fh_addr_reg <= '0;
        end else begin
            state_reg   <= state_next;
            eot_reg     <= eot_next;
            drop_reg    <= drop_next;
            cnt_reg     <= cnt_next;
            fh_addr_reg <= fromhost_addr_i;
        end
    end

`ifdef RVFI_HTIF_SYSCALL_EN
    logic [63:0] payload_reg, payload_next;
    logic [63:0] resp_reg, resp_next;

    // Payload captured only when a syscall is actually taken; response only on a consumed ack.
    always_comb begin
        payload_next = payload_reg;
        resp_next    = resp_reg;
        if ((state_reg == HTIF_IDLE) && (state_next == HTIF_REQ)) begin
            payload_next = m_wdata;
        end
        if ((state_reg == HTIF_REQ) && sys_ack_i && (state_next != HTIF_DONE)) begin
            resp_next = sys_resp_i;
        end
    end

    // Syscall payload and host response holding registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            payload_reg <= '0;
            resp_reg    <= '0;
        end else begin
            payload_reg <= payload_next;
            resp_reg    <= resp_next;
        end
    end

    assign sys_req_o     = (state_reg == HTIF_REQ);
    assign fh_we_o       = (state_reg == HTIF_FH_WR);
    assign sys_payload_o = payload_reg;
    assign fh_wdata_o    = resp_reg;

    logic unused_sig;
    assign unused_sig = ^m_idx;
`else
    assign sys_req_o     = 1'b0;
    assign fh_we_o       = 1'b0;
    assign sys_payload_o = '0;
    assign fh_wdata_o    = '0;

    logic unused_sig;
    assign unused_sig = ^{m_idx, m_wdata[63:32], sys_ack_i, sys_resp_i, fh_gnt_i};
`endif

    assign busy_o        = (state_reg != HTIF_IDLE);
    assign dropped_o     = drop_reg;
    assign end_of_test_o = eot_reg;
    assign fh_addr_o     = fh_addr_reg;

endmodule

// File: tb/tb_rvfi_htif_ctrl.sv
// Self-checking bench for rvfi_htif_ctrl: single-commit vector table through a
// scoreboard queue, plus hand-written multi-cycle sequences.
module tb_rvfi_htif_ctrl;
    import rvfi_htif_pkg::*;

    localparam htif_cfg_t   CFG      = '{NrCommitPorts: 32'd2};
`ifdef RVFI_HTIF_SYSCALL_EN
    localparam bit          SYS      = 1'b1;
`else
    localparam bit          SYS      = 1'b0;
`endif
    localparam logic [63:0] TOHOST   = 64'h8000_1000;
    localparam logic [63:0] FROMHOST = 64'h8000_1040;
    localparam logic [63:0] SCALL    = 64'h8000_2000;
    localparam int          NV       = 11;

    logic             clk_i;
    logic             rst_ni;
    htif_rvfi_instr_t rvfi [2];
    logic [63:0]      tohost_addr, fromhost_addr;
    logic             sys_req;
    logic [63:0]      sys_payload;
    logic             sys_ack;
    logic [63:0]      sys_resp;
    logic             fh_we;
    logic [63:0]      fh_addr;
    logic [63:0]      fh_wdata;
    logic             fh_gnt;
    logic             busy;
    logic [7:0]       dropped;
    logic [31:0]      eot;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [63:0] tohost;
        logic        v0;
        logic [7:0]  m0;
        logic [63:0] a0;
        logic [63:0] d0;
        logic        v1;
        logic [63:0] a1;
        logic [63:0] d1;
        logic [31:0] e_eot;
        logic        e_req;
        logic [63:0] e_pay;
        logic [7:0]  e_drop;
        logic        e_busy;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] eot;
        logic        req;
        logic [63:0] pay;
        logic [7:0]  drop;
        logic        busy;
    } exp_t;

    vec_t tbl [NV];
    exp_t sb_q [$];

    rvfi_htif_ctrl #(
        .CVA6Cfg        (CFG),
        .rvfi_instr_t   (htif_rvfi_instr_t),
        .TIMEOUT_CYCLES (32'd100)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .rvfi_i          (rvfi),
        .tohost_addr_i   (tohost_addr),
        .fromhost_addr_i (fromhost_addr),
        .sys_req_o       (sys_req),
        .sys_payload_o   (sys_payload),
        .sys_ack_i       (sys_ack),
        .sys_resp_i      (sys_resp),
        .fh_we_o         (fh_we),
        .fh_addr_o       (fh_addr),
        .fh_wdata_o      (fh_wdata),
        .fh_gnt_i        (fh_gnt),
        .busy_o          (busy),
        .dropped_o       (dropped),
        .end_of_test_o   (eot)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        for (int p = 0; p < 2; p++) rvfi[p] = '0;
        sys_ack  = 1'b0;
        sys_resp = '0;
        fh_gnt   = 1'b0;
    endtask

    task automatic store(input int p, input logic [63:0] d);
        rvfi[p].valid     = 1'b1;
        rvfi[p].mem_wmask = 8'hFF;
        rvfi[p].mem_paddr = tohost_addr;
        rvfi[p].mem_wdata = d;
    endtask

    // Reset for two edges, release on a falling edge; cycle counter starts at 0 there.
    task automatic do_reset(input logic [63:0] th, input logic [63:0] fh);
        rst_ni        = 1'b0;
        tohost_addr   = th;
        fromhost_addr = fh;
        clear_inputs();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        exp_t e;
        rst_ni        = 1'b0;
        tohost_addr   = TOHOST;
        fromhost_addr = FROMHOST;
        clear_inputs();

        //           tohost   v0 m0     a0         d0                      v1 a1      d1       eot         req  pay                    drop                 busy
        tbl[0]  = '{TOHOST, 1, 8'hFF, TOHOST,    64'h1,                  0, '0,     '0,      32'h1,      0,   '0,                    8'd0,                1};
        tbl[1]  = '{TOHOST, 1, 8'hFF, TOHOST,    SCALL,                  0, '0,     '0,      32'h0,      SYS, SYS ? SCALL : 64'h0,   SYS ? 8'd0 : 8'd1,   SYS};
        tbl[2]  = '{TOHOST, 1, 8'hFF, TOHOST,    SCALL,                  1, TOHOST, 64'h3,   32'h0,      SYS, SYS ? SCALL : 64'h0,   SYS ? 8'd1 : 8'd2,   SYS};
        tbl[3]  = '{TOHOST, 0, 8'hFF, TOHOST,    64'h1,                  1, TOHOST, 64'h5,   32'h5,      0,   '0,                    8'd0,                1};
        tbl[4]  = '{TOHOST, 1, 8'hFF, TOHOST,    64'h0,                  0, '0,     '0,      32'h0,      0,   '0,                    8'd0,                0};
        tbl[5]  = '{TOHOST, 1, 8'hFF, TOHOST+8,  64'h1,                  0, '0,     '0,      32'h0,      0,   '0,                    8'd0,                0};
        tbl[6]  = '{TOHOST, 1, 8'h00, TOHOST,    64'h1,                  0, '0,     '0,      32'h0,      0,   '0,                    8'd0,                0};
        tbl[7]  = '{64'h0,  1, 8'hFF, 64'h0,     64'h1,                  1, 64'h0,  64'h3,   32'h0,      0,   '0,                    8'd0,                0};
        tbl[8]  = '{TOHOST, 1, 8'hFF, TOHOST,    64'h7,                  1, TOHOST, 64'h9,   32'h7,      0,   '0,                    8'd1,                1};
        tbl[9]  = '{TOHOST, 0, 8'hFF, TOHOST,    64'h1,                  1, TOHOST, 64'h100, 32'h0,      SYS, SYS ? 64'h100 : 64'h0, SYS ? 8'd0 : 8'd1,   SYS};
        tbl[10] = '{TOHOST, 1, 8'hFF, TOHOST,    64'hDEAD_BEEF_0000_0013, 0, '0,    '0,      32'h13,     0,   '0,                    8'd0,                1};

        // Reset values, sampled while reset is held.
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_req", {63'd0, sys_req}, 64'd0);
        chk("rst_payload", sys_payload, 64'd0);
        chk("rst_fh_we", {63'd0, fh_we}, 64'd0);
        chk("rst_fh_addr", fh_addr, 64'd0);
        chk("rst_fh_wdata", fh_wdata, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_dropped", {56'd0, dropped}, 64'd0);
        chk("rst_eot", {32'd0, eot}, 64'd0);
        $display("seq reset_values checked");

        // Single-commit vectors: expected pushed at drive, popped one cycle later.
        for (int i = 0; i < NV; i++) begin
            do_reset(tbl[i].tohost, FROMHOST);
            rvfi[0] = '{valid: tbl[i].v0, mem_wmask: tbl[i].m0, mem_paddr: tbl[i].a0, mem_wdata: tbl[i].d0};
            rvfi[1] = '{valid: tbl[i].v1, mem_wmask: 8'hFF, mem_paddr: tbl[i].a1, mem_wdata: tbl[i].d1};
            sb_q.push_back('{id: i, eot: tbl[i].e_eot, req: tbl[i].e_req, pay: tbl[i].e_pay,
                             drop: tbl[i].e_drop, busy: tbl[i].e_busy});
            step();
            clear_inputs();
            if (sb_q.size() == 0) begin
                chk($sformatf("v%0d_scoreboard_empty", i), 64'd0, 64'd1);
            end else begin
                e = sb_q.pop_front();
                chk($sformatf("v%0d_eot", e.id), {32'd0, eot}, {32'd0, e.eot});
                chk($sformatf("v%0d_req", e.id), {63'd0, sys_req}, {63'd0, e.req});
                chk($sformatf("v%0d_payload", e.id), sys_payload, e.pay);
                chk($sformatf("v%0d_dropped", e.id), {56'd0, dropped}, {56'd0, e.drop});
                chk($sformatf("v%0d_busy", e.id), {63'd0, busy}, {63'd0, e.busy});
            end
            $display("vec %0d v0=%0b d0=0x%0h v1=%0b d1=0x%0h eot=0x%0h drop=%0d",
                     i, tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1, eot, dropped);
        end

        // DONE absorbs later exits, drop counter saturates, exit code survives the timeout.
        do_reset(TOHOST, FROMHOST);
        store(0, 64'h1);
        step();
        clear_inputs();
        chk("sat_eot_first", {32'd0, eot}, 64'h1);
        store(0, 64'h3);
        store(1, 64'h5);
        repeat (127) @(posedge clk_i);
        @(negedge clk_i);
        chk("sat_dropped_254", {56'd0, dropped}, 64'd254);
        step();
        chk("sat_dropped_255", {56'd0, dropped}, 64'd255);
        step();
        chk("sat_dropped_hold", {56'd0, dropped}, 64'd255);
        chk("sat_eot_sticky", {32'd0, eot}, 64'h1);
        clear_inputs();
        $display("seq saturation dropped=%0d eot=0x%0h", dropped, eot);

        // Asynchronous reset clears state without waiting for an edge.
        @(posedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        chk("async_rst_eot", {32'd0, eot}, 64'd0);
        chk("async_rst_busy", {63'd0, busy}, 64'd0);
        chk("async_rst_dropped", {56'd0, dropped}, 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        $display("seq async_reset_done_state");

        // Timeout: 100 edges quiet, forced exit on the next one.
        do_reset(TOHOST, FROMHOST);
        repeat (100) @(posedge clk_i);
        @(negedge clk_i);
        chk("to_eot_before", {32'd0, eot}, 64'd0);
        chk("to_busy_before", {63'd0, busy}, 64'd0);
        step();
        chk("to_eot_after", {32'd0, eot}, 64'hFFFF_FFFF);
        chk("to_busy_after", {63'd0, busy}, 64'd1);
        $display("seq timeout eot=0x%0h", eot);

        // Exit sampled on the timeout edge wins.
        do_reset(TOHOST, FROMHOST);
        repeat (100) @(posedge clk_i);
        @(negedge clk_i);
        store(0, 64'h11);
        step();
        clear_inputs();
        chk("exit_vs_timeout", {32'd0, eot}, 64'h11);
        $display("seq exit_vs_timeout eot=0x%0h", eot);

`ifdef RVFI_HTIF_SYSCALL_EN
        // Full syscall with write-back, extended ack, and back-to-back request.
        do_reset(TOHOST, FROMHOST);
        store(0, SCALL);
        step();
        clear_inputs();
        chk("sc_req_up", {63'd0, sys_req}, 64'd1);
        chk("sc_payload", sys_payload, SCALL);
        store(0, 64'h1);
        step();
        clear_inputs();
        chk("sc_exit_in_req_dropped", {56'd0, dropped}, 64'd1);
        chk("sc_exit_in_req_eot", {32'd0, eot}, 64'd0);
        chk("sc_req_waiting", {63'd0, sys_req}, 64'd1);
        step();
        sys_ack  = 1'b1;
        sys_resp = 64'h2A;
        step();
        chk("sc_req_drop_on_ack", {63'd0, sys_req}, 64'd0);
        chk("sc_fh_we_up", {63'd0, fh_we}, 64'd1);
        chk("sc_fh_wdata", fh_wdata, 64'h2A);
        chk("sc_fh_addr", fh_addr, FROMHOST);
        sys_resp = 64'h55;
        step();
        sys_ack = 1'b0;
        chk("sc_ack_held_ignored", fh_wdata, 64'h2A);
        chk("sc_fh_we_hold", {63'd0, fh_we}, 64'd1);
        fh_gnt = 1'b1;
        step();
        fh_gnt = 1'b0;
        chk("sc_fh_we_drop", {63'd0, fh_we}, 64'd0);
        chk("sc_idle", {63'd0, busy}, 64'd0);
        chk("sc_eot_zero", {32'd0, eot}, 64'd0);
        chk("sc_payload_kept", sys_payload, SCALL);
        store(0, 64'h8000_3000);
        step();
        clear_inputs();
        chk("sc_back_to_back_req", {63'd0, sys_req}, 64'd1);
        chk("sc_back_to_back_payload", sys_payload, 64'h8000_3000);
        $display("seq syscall_writeback resp=0x%0h", fh_wdata);

        // No write-back address: ack returns straight to IDLE.
        do_reset(TOHOST, 64'h0);
        store(0, SCALL);
        step();
        clear_inputs();
        sys_ack  = 1'b1;
        sys_resp = 64'h7;
        step();
        sys_ack = 1'b0;
        chk("nowb_req", {63'd0, sys_req}, 64'd0);
        chk("nowb_fh_we", {63'd0, fh_we}, 64'd0);
        chk("nowb_busy", {63'd0, busy}, 64'd0);
        step();
        chk("nowb_fh_we_later", {63'd0, fh_we}, 64'd0);
        $display("seq syscall_no_writeback");

        // Timeout abandons a pending request.
        do_reset(TOHOST, FROMHOST);
        store(0, SCALL);
        step();
        clear_inputs();
        repeat (99) @(posedge clk_i);
        @(negedge clk_i);
        chk("to_req_pending", {63'd0, sys_req}, 64'd1);
        step();
        chk("to_req_abandoned", {63'd0, sys_req}, 64'd0);
        chk("to_req_eot", {32'd0, eot}, 64'hFFFF_FFFF);
        $display("seq timeout_in_req");

        // Reset asserted during FH_WR.
        do_reset(TOHOST, FROMHOST);
        store(0, SCALL);
        step();
        clear_inputs();
        sys_ack  = 1'b1;
        sys_resp = 64'h2A;
        step();
        sys_ack = 1'b0;
        chk("mid_fh_we", {63'd0, fh_we}, 64'd1);
        @(posedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        chk("mid_rst_fh_we", {63'd0, fh_we}, 64'd0);
        chk("mid_rst_fh_wdata", fh_wdata, 64'd0);
        chk("mid_rst_payload", sys_payload, 64'd0);
        chk("mid_rst_fh_addr", fh_addr, 64'd0);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        $display("seq reset_in_fh_wr");
`else
        // Syscall stores are dropped and leave the FSM able to take an exit.
        do_reset(TOHOST, FROMHOST);
        store(0, SCALL);
        step();
        store(0, 64'h1);
        chk("nosys_req", {63'd0, sys_req}, 64'd0);
        chk("nosys_busy", {63'd0, busy}, 64'd0);
        chk("nosys_dropped", {56'd0, dropped}, 64'd1);
        step();
        clear_inputs();
        chk("nosys_exit", {32'd0, eot}, 64'h1);
        chk("nosys_fh_we", {63'd0, fh_we}, 64'd0);
        $display("seq syscall_disabled");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
